ritc_idelay_loader: RTL

- Sits directly downstream of the RITC IDELAY register interface.
- Takes its delay value, target address, load bit and per-bank IDELAYCTRL ready, and runs the load sequence into the IDELAYE2 array of 3 banks × 16 taps.
- Sequence: wait for bank ready, pulse LD with CNTVALUEIN, wait settle cycles, read back CNTVALUEOUT and compare.
- Reports busy/done/error status back to the register block so software can poll completion.

---
 rtl/ritc_idelay_pkg.sv | 29 ++
 rtl/ritc_rdy_sync.sv | 18 +
 rtl/ritc_idelay_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ritc_idelay_pkg.sv
// Shared constants, status codes and FSM encoding for the RITC IDELAY loader.
// Address space: 0..47 single tap, 63 broadcast, 48..62 invalid.
package ritc_idelay_pkg;
  localparam int NBANK = 3;
  localparam int NCH   = 16;
  localparam int NTAP  = NBANK * NCH;

  localparam logic [5:0] BROADCAST_ADDR = 6'd63;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_VERIFY  = 2'd3;

  // DONE and ERR are not held as states: their status updates are registered
  // on the exit edge of VERIFY/CHECK/WAIT_RDY, which then returns to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_RDY,
    ST_LOAD,
    ST_SETTLE,
    ST_VERIFY
  } state_t;

  function automatic logic addr_invalid(input logic [5:0] a);
    return (a >= 6'(NTAP)) && (a != BROADCAST_ADDR);
  endfunction
endpackage

// File: rtl/ritc_rdy_sync.sv
// Per-bit two-flop synchroniser for the IDELAYCTRL ready lines.
module ritc_rdy_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic [1:0] r_sh;
    always_ff @(posedge i_clk) begin
      if (i_rst) r_sh <= '0;
      else       r_sh <= {r_sh[0], i_async[gi]};
    end
    assign o_sync[gi] = r_sh[1];
  end
endmodule

// File: rtl/ritc_idelay_loader.sv
// Runs the IDELAYE2 load sequence (ready wait, LD pulse, settle, readback verify)
// for one tap or all taps, and reports busy/done/error status.
module ritc_idelay_loader
  import ritc_idelay_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [4:0]          delay_i,
  input  logic [5:0]          addr_i,
  input  logic                load_i,
  input  logic [NBANK-1:0]    ready_i,
  output logic [NTAP-1:0]     idelay_ld_o,
  output logic [4:0]          idelay_cntvaluein_o,
  input  logic [5*NTAP-1:0]   idelay_cntvalueout_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);
  state_t          r_state;
  logic [4:0]      r_delay;
  logic [5:0]      r_addr;
  logic [7:0]      r_cnt;
  logic [NTAP-1:0] r_ld;
  logic            r_load_prev;
  logic            r_arm;
  logic            r_busy, r_done, r_err;
  logic [1:0]      r_code;

  logic [NBANK-1:0] w_rdy_sync;
  logic [3:0]       w_rdy_pad;
  logic [NTAP-1:0]  w_eq;
  logic [63:0]      w_eq_pad;
  logic             w_bcast, w_rdy_ok, w_verify_ok, w_trig;

  ritc_rdy_sync #(.W(NBANK)) u_rdy_sync (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_async (ready_i),
    .o_sync  (w_rdy_sync)
  );

  for (genvar gi = 0; gi < NTAP; gi++) begin : g_cmp
    assign w_eq[gi] = (idelay_cntvalueout_i[5*gi +: 5] == r_delay);
  end

  assign w_bcast     = (r_addr == BROADCAST_ADDR);
  assign w_rdy_pad   = 4'(w_rdy_sync);
  assign w_eq_pad    = 64'(w_eq);
  assign w_rdy_ok    = w_bcast ? (&w_rdy_sync) : w_rdy_pad[r_addr[5:4]];
  assign w_verify_ok = w_bcast ? (&w_eq) : w_eq_pad[r_addr];
  // r_arm blocks a level already high when reset is released from looking like an edge.
  assign w_trig      = load_i & ~r_load_prev & r_arm;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_delay     <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_ld        <= '0;
      r_load_prev <= 1'b0;
      r_arm       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= ERR_NONE;
    end else begin
      r_load_prev <= load_i;
      r_arm       <= 1'b1;
      r_ld        <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_delay <= delay_i;
            r_addr  <= addr_i;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_cnt <= '0;
          if (addr_invalid(r_addr)) begin
            r_err   <= 1'b1;
            r_code  <= ERR_ADDR;
            r_busy  <= 1'b0;
            r_delay <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (w_rdy_ok) begin
            r_ld    <= w_bcast ? '1 : (NTAP'(1) << r_addr);
            r_state <= ST_LOAD;
          end else if (r_cnt == 8'(RDY_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_code  <= ERR_TIMEOUT;
            r_busy  <= 1'b0;
            r_delay <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == 8'(SETTLE_CYCLES - 1)) r_state <= ST_VERIFY;
          else                                r_cnt   <= r_cnt + 8'd1;
        end
        ST_VERIFY: begin
          if (w_verify_ok) begin
            r_done <= 1'b1;
          end else begin
            r_err  <= 1'b1;
            r_code <= ERR_VERIFY;
          end
          r_busy  <= 1'b0;
          r_delay <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign idelay_ld_o         = r_ld;
  assign idelay_cntvaluein_o = r_delay;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign err_o               = r_err;
  assign err_code_o          = r_code;
endmodule
